// File: rtl/bus_change_capture.sv
// Watches a registered bus and queues each change as {new value, idle-cycle delta}
// in a small first-word-fall-through FIFO drained over a valid/ready handshake.
module bus_change_capture #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inBus,
    input  logic             clrOvf,
    input  logic             outReady,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic [CNT_W-1:0] outDelta,
    output logic [LW-1:0]    level,
    output logic             overflow
);

    logic [WIDTH-1:0] dmem [DEPTH];
    logic [CNT_W-1:0] cmem [DEPTH];
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             change;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        change   = (inBus != prev);
        full     = (level == LW'(DEPTH));
        outValid = (level != '0);
        pop      = outValid && outReady;
        push     = change && (!full || pop);
        drop     = change && full && !pop;
        outData  = dmem[rptr];
        outDelta = cmem[rptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= inBus;
            if (change) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem[i] <= '0;
                cmem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                dmem[wptr] <= inBus;
                cmem[wptr] <= cnt;
                wptr       <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Set beats clear when a drop and clrOvf coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clrOvf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_change_capture.sv
// Directed, self-checking bench for bus_change_capture with hand-computed expectations.
module tb_bus_change_capture;

    logic       clk;
    logic       rst;
    logic [9:0] inBus;
    logic       clrOvf;
    logic       outReady;
    logic       outValid;
    logic [9:0] outData;
    logic [7:0] outDelta;
    logic [2:0] level;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    bus_change_capture dut (
        .clk      (clk),
        .rst      (rst),
        .inBus    (inBus),
        .clrOvf   (clrOvf),
        .outReady (outReady),
        .outValid (outValid),
        .outData  (outData),
        .outDelta (outDelta),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] bus, input int cycles);
        inBus = bus;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic checkHead(input string tag, input logic [9:0] d, input logic [7:0] dl);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".data"},  32'(outData),  32'(d));
        checkOutput({tag, ".delta"}, 32'(outDelta), 32'(dl));
    endtask

    task automatic popOne();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        inBus    = '0;
        clrOvf   = 1'b0;
        outReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst.valid",    32'(outValid), 32'd0);
        checkOutput("rst.level",    32'(level),    32'd0);
        checkOutput("rst.overflow", 32'(overflow), 32'd0);
        checkOutput("rst.data",     32'(outData),  32'd0);
        checkOutput("rst.delta",    32'(outDelta), 32'd0);

        // Test 1: five idle cycles then a single change
        applyStimulus(10'h000, 5);
        applyStimulus(10'h155, 1);
        checkHead("t1.head", 10'h155, 8'd5);
        checkOutput("t1.level",    32'(level),    32'd1);
        checkOutput("t1.overflow", 32'(overflow), 32'd0);
        popOne();
        checkOutput("t1.empty", 32'(outValid), 32'd0);

        // Test 2: back-to-back changes after three idle cycles in total
        applyStimulus(10'h155, 2);
        applyStimulus(10'h001, 1);
        applyStimulus(10'h002, 1);
        applyStimulus(10'h003, 1);
        checkOutput("t2.level", 32'(level), 32'd3);
        checkHead("t2.e0", 10'h001, 8'd3);
        popOne();
        checkHead("t2.e1", 10'h002, 8'd0);
        popOne();
        checkHead("t2.e2", 10'h003, 8'd0);
        popOne();
        checkOutput("t2.level0", 32'(level), 32'd0);

        // Test 3: DEPTH+2 changes with no pops, then drain
        applyStimulus(10'h010, 1);
        applyStimulus(10'h020, 1);
        applyStimulus(10'h030, 1);
        applyStimulus(10'h040, 1);
        checkOutput("t3.ovf_before", 32'(overflow), 32'd0);
        applyStimulus(10'h050, 1);
        applyStimulus(10'h060, 1);
        checkOutput("t3.level",    32'(level),    32'd4);
        checkOutput("t3.overflow", 32'(overflow), 32'd1);
        checkHead("t3.e0", 10'h010, 8'd3);
        popOne();
        checkHead("t3.e1", 10'h020, 8'd0);
        popOne();
        checkHead("t3.e2", 10'h030, 8'd0);
        popOne();
        checkHead("t3.e3", 10'h040, 8'd0);
        popOne();
        checkOutput("t3.drained", 32'(level), 32'd0);
        applyStimulus(10'h070, 1);
        checkHead("t3.after", 10'h070, 8'd4);
        checkOutput("t3.ovf_sticky", 32'(overflow), 32'd1);
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        checkOutput("t3.ovf_clr", 32'(overflow), 32'd0);

        // Test 4: full FIFO with simultaneous push and pop
        applyStimulus(10'h071, 1);
        applyStimulus(10'h072, 1);
        applyStimulus(10'h073, 1);
        checkOutput("t4.full", 32'(level), 32'd4);
        outReady = 1'b1;
        applyStimulus(10'h3FF, 1);
        outReady = 1'b0;
        checkOutput("t4.level",    32'(level),    32'd4);
        checkOutput("t4.overflow", 32'(overflow), 32'd0);
        checkHead("t4.e0", 10'h071, 8'd1);
        popOne();
        checkHead("t4.e1", 10'h072, 8'd0);
        popOne();
        checkHead("t4.e2", 10'h073, 8'd0);
        popOne();
        checkHead("t4.tail", 10'h3FF, 8'd0);
        popOne();
        checkOutput("t4.empty", 32'(outValid), 32'd0);

        // Test 5: delta saturates at 255
        applyStimulus(10'h3FF, 300);
        applyStimulus(10'h2AA, 1);
        checkHead("t5.sat", 10'h2AA, 8'd255);
        popOne();

        // Set wins when a drop and clrOvf coincide
        applyStimulus(10'h001, 1);
        applyStimulus(10'h002, 1);
        applyStimulus(10'h003, 1);
        applyStimulus(10'h004, 1);
        clrOvf = 1'b1;
        applyStimulus(10'h005, 1);
        clrOvf = 1'b0;
        checkOutput("t5.setwins", 32'(overflow), 32'd1);
        popOne();
        checkOutput("t6.queued", 32'(level), 32'd3);

        // Test 6: asynchronous reset with events queued
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6.valid",    32'(outValid), 32'd0);
        checkOutput("t6.level",    32'(level),    32'd0);
        checkOutput("t6.overflow", 32'(overflow), 32'd0);
        #1;
        inBus    = 10'h000;
        rst      = 1'b0;
        outReady = 1'b1;
        tick();
        tick();
        outReady = 1'b0;
        checkOutput("t6.noevent", 32'(outValid), 32'd0);
        checkOutput("t6.level0",  32'(level),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
